// File: rtl/vga_render.sv
// Text-mode pixel pipeline: screen RAM -> font ROM -> shift register, with syncs delayed 5 clocks.
// Optional blinking cursor is enabled by defining VGA_CURSOR_EN.
module vga_render #(
    parameter int unsigned COLUMNS = 80,
    parameter int unsigned PIXELS  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              de,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              glyph,
    input  logic [6:0]        h_glyph,
    input  logic [4:0]        v_glyph,
    input  logic [4:0]        v_pixel,
    output logic [10:0]       screen_addr,
    input  logic [7:0]        screen_data,
    output logic [11:0]       font_addr,
    input  logic [PIXELS-1:0] font_data,
    input  logic [4:0]        cursor_row,
    input  logic [6:0]        cursor_col,
    input  logic              cursor_enable,
    output logic              de_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              pixel
);
    localparam int unsigned SAW = 11;

    logic [4:0]        v_pixel_d1, v_pixel_d2;
    logic              glyph_d1, glyph_d2, glyph_d3, glyph_d4;
    logic              de_d1, de_d2, de_d3, de_d4;
    logic              hs_d1, hs_d2, hs_d3, hs_d4;
    logic              vs_d1, vs_d2, vs_d3, vs_d4;
    logic              inverse_d3, inverse_d4;
    logic [PIXELS-1:0] shift;
    logic              inv;
    logic              cursor_on;

    // Five-stage pipeline; sidebands travel in lockstep with the RAM/ROM reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            screen_addr <= '0;
            font_addr   <= '0;
            v_pixel_d1  <= '0;
            v_pixel_d2  <= '0;
            glyph_d1    <= 1'b0;
            glyph_d2    <= 1'b0;
            glyph_d3    <= 1'b0;
            glyph_d4    <= 1'b0;
            de_d1       <= 1'b0;
            de_d2       <= 1'b0;
            de_d3       <= 1'b0;
            de_d4       <= 1'b0;
            hs_d1       <= 1'b0;
            hs_d2       <= 1'b0;
            hs_d3       <= 1'b0;
            hs_d4       <= 1'b0;
            vs_d1       <= 1'b0;
            vs_d2       <= 1'b0;
            vs_d3       <= 1'b0;
            vs_d4       <= 1'b0;
            inverse_d3  <= 1'b0;
            inverse_d4  <= 1'b0;
            shift       <= '0;
            inv         <= 1'b0;
            de_out      <= 1'b0;
            hsync_out   <= 1'b0;
            vsync_out   <= 1'b0;
        end else begin
            screen_addr <= SAW'(v_glyph) * SAW'(COLUMNS) + SAW'(h_glyph);
            v_pixel_d1  <= v_pixel;
            glyph_d1    <= glyph;
            de_d1       <= de;
            hs_d1       <= hsync;
            vs_d1       <= vsync;

            v_pixel_d2  <= v_pixel_d1;
            glyph_d2    <= glyph_d1;
            de_d2       <= de_d1;
            hs_d2       <= hs_d1;
            vs_d2       <= vs_d1;

            font_addr   <= {screen_data[6:0], v_pixel_d2};
            inverse_d3  <= screen_data[7];
            glyph_d3    <= glyph_d2;
            de_d3       <= de_d2;
            hs_d3       <= hs_d2;
            vs_d3       <= vs_d2;

            inverse_d4  <= inverse_d3;
            glyph_d4    <= glyph_d3;
            de_d4       <= de_d3;
            hs_d4       <= hs_d3;
            vs_d4       <= vs_d3;

            if (glyph_d4) begin
                shift <= font_data;
                inv   <= inverse_d4 ^ cursor_on;
            end else begin
                shift <= {shift[PIXELS-2:0], 1'b0};
            end
            de_out    <= de_d4;
            hsync_out <= hs_d4;
            vsync_out <= vs_d4;
        end
    end

`ifdef VGA_CURSOR_EN
    logic [4:0] frame_count;
    logic       match_d1, match_d2, match_d3, match_d4;

    // Frame counter drives a 16-on/16-off blink; match travels with the glyph.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= '0;
            match_d1    <= 1'b0;
            match_d2    <= 1'b0;
            match_d3    <= 1'b0;
            match_d4    <= 1'b0;
        end else begin
            if (vsync && !vs_d1) begin
                frame_count <= frame_count + 5'd1;
            end
            match_d1 <= (v_glyph == cursor_row) && (h_glyph == cursor_col);
            match_d2 <= match_d1;
            match_d3 <= match_d2;
            match_d4 <= match_d3;
        end
    end

    assign cursor_on = cursor_enable & match_d4 & ~frame_count[4];
`else
    logic cursor_unused;

    assign cursor_unused = ^{cursor_row, cursor_col, cursor_enable};
    assign cursor_on     = 1'b0;
`endif

    assign pixel = de_out & (shift[PIXELS-1] ^ inv);

endmodule

// File: tb/tb_vga_render.sv
// Directed self-checking bench for vga_render with behavioural screen RAM and font ROM.
// Cursor expectations follow VGA_CURSOR_EN when the bench is built with it.
module tb_vga_render;
    logic        clk = 1'b0;
    logic        reset, de, hsync, vsync, glyph;
    logic [6:0]  h_glyph;
    logic [4:0]  v_glyph, v_pixel;
    logic [10:0] screen_addr;
    logic [7:0]  screen_data;
    logic [11:0] font_addr;
    logic [9:0]  font_data;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic        cursor_enable;
    logic        de_out, hsync_out, vsync_out, pixel;

    int checks = 0;
    int errors = 0;

    logic [7:0] screen_mem [2048];
    logic [9:0] font_mem   [4096];

    always #5 clk = ~clk;

    // Synchronous memories with one clock of read latency.
    always @(posedge clk) begin
        screen_data <= screen_mem[screen_addr];
        font_data   <= font_mem[font_addr];
    end

    vga_render #(.COLUMNS(80), .PIXELS(10)) dut (
        .clk(clk), .reset(reset), .de(de), .hsync(hsync), .vsync(vsync),
        .glyph(glyph), .h_glyph(h_glyph), .v_glyph(v_glyph), .v_pixel(v_pixel),
        .screen_addr(screen_addr), .screen_data(screen_data),
        .font_addr(font_addr), .font_data(font_data),
        .cursor_row(cursor_row), .cursor_col(cursor_col), .cursor_enable(cursor_enable),
        .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .pixel(pixel)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        de = 1'b0; hsync = 1'b0; vsync = 1'b0; glyph = 1'b0;
        h_glyph = '0; v_glyph = '0; v_pixel = '0;
    endtask

    // Strobe one glyph with de high for 10 cycles and capture its 10 output pixels.
    task automatic run_glyph(input logic [4:0] v, input logic [6:0] h, input logic [4:0] vp,
                             output logic [9:0] got);
        glyph = 1'b1; de = 1'b1; v_glyph = v; h_glyph = h; v_pixel = vp;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 1) glyph = 1'b0;
            if (k == 10) de = 1'b0;
            if (k >= 5) got[14-k] = pixel;
        end
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        de = 1'b1; hsync = 1'b1; vsync = 1'b1; glyph = 1'b1;
        h_glyph = 7'd5; v_glyph = 5'd2; v_pixel = 5'd3;
        repeat (3) tick();
        checks++;
        if (screen_addr !== 11'd0) begin
            errors++; $display("FAIL reset_screen_addr got %0d exp 0", screen_addr);
        end
        checks++;
        if (font_addr !== 12'd0) begin
            errors++; $display("FAIL reset_font_addr got %0d exp 0", font_addr);
        end
        checks++;
        if ({de_out, hsync_out, vsync_out, pixel} !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs got %b exp 0000", {de_out, hsync_out, vsync_out, pixel});
        end
        reset = 1'b0;
        idle_inputs();
        repeat (6) tick();
    endtask

    task automatic test_pipeline;
        logic [9:0] got;
        logic [9:0] exp;
        exp = 10'b1100000011;
        screen_mem[0] = 8'h41;
        font_mem[{7'h41, 5'd0}] = 10'b1100000011;
        run_glyph(5'd0, 7'd0, 5'd0, got);
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL pipeline_pixels got %b exp %b", got, exp);
        end
    endtask

    task automatic test_back_to_back;
        logic [19:0] got;
        logic [19:0] exp;
        exp = {10'b1100000011, 10'b1011001101};
        screen_mem[1] = 8'h42;
        font_mem[{7'h42, 5'd4}] = 10'b1011001101;
        font_mem[{7'h41, 5'd4}] = 10'b1100000011;
        de = 1'b1; v_glyph = 5'd0; v_pixel = 5'd4;
        for (int k = 0; k <= 24; k++) begin
            glyph   = (k == 0 || k == 10);
            h_glyph = (k < 10) ? 7'd0 : 7'd1;
            if (k == 20) de = 1'b0;
            tick();
            if (k >= 4) got[23-k] = pixel;
        end
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL back_to_back got %b exp %b", got, exp);
        end
        idle_inputs();
        repeat (6) tick();
    endtask

    task automatic test_address;
        screen_mem[1919] = 8'h7F;
        h_glyph = 7'd79; v_glyph = 5'd23; v_pixel = 5'd19;
        tick();
        h_glyph = 7'd40; v_glyph = 5'd12; v_pixel = 5'd0;
        checks++;
        if (screen_addr !== 11'd1919) begin
            errors++; $display("FAIL addr_max got %0d exp 1919", screen_addr);
        end
        tick();
        h_glyph = 7'd0; v_glyph = 5'd1;
        checks++;
        if (screen_addr !== 11'd1000) begin
            errors++; $display("FAIL addr_mid got %0d exp 1000", screen_addr);
        end
        tick();
        checks++;
        if (font_addr !== 12'hFF3) begin
            errors++; $display("FAIL font_addr got %h exp ff3", font_addr);
        end
        checks++;
        if (screen_addr !== 11'd80) begin
            errors++; $display("FAIL addr_row1 got %0d exp 80", screen_addr);
        end
        idle_inputs();
        repeat (6) tick();
    endtask

    task automatic test_inverse;
        logic [9:0] got;
        logic [9:0] exp;
        exp = 10'b0011111100;
        screen_mem[0] = 8'hC1;
        run_glyph(5'd0, 7'd0, 5'd0, got);
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL inverse_pixels got %b exp %b", got, exp);
        end
        screen_mem[0] = 8'h41;
    endtask

    task automatic test_sync;
        logic [24:0] de_pat, hs_pat, vs_pat;
        de_pat = 25'b1111111100000111111100000;
        hs_pat = 25'b0011100000000011110000110;
        vs_pat = 25'b0000001111111000000011000;
        for (int c = 0; c < 30; c++) begin
            de    = (c < 25) ? de_pat[c] : 1'b0;
            hsync = (c < 25) ? hs_pat[c] : 1'b0;
            vsync = (c < 25) ? vs_pat[c] : 1'b0;
            glyph = (c == 0);
            h_glyph = '0; v_glyph = '0; v_pixel = '0;
            tick();
            if (c >= 4 && c - 4 < 25) begin
                checks++;
                if ({de_out, hsync_out, vsync_out} !== {de_pat[c-4], hs_pat[c-4], vs_pat[c-4]}) begin
                    errors++;
                    $display("FAIL sync_delay cycle %0d got %b exp %b", c - 4,
                             {de_out, hsync_out, vsync_out}, {de_pat[c-4], hs_pat[c-4], vs_pat[c-4]});
                end
                if (de_pat[c-4] == 1'b0) begin
                    checks++;
                    if (pixel !== 1'b0) begin
                        errors++; $display("FAIL blank_mask cycle %0d got %b exp 0", c - 4, pixel);
                    end
                end
            end
        end
        idle_inputs();
        repeat (6) tick();
    endtask

    task automatic test_reset_midline;
        logic [9:0] got;
        logic [9:0] exp;
        exp = 10'b1100000011;
        glyph = 1'b1; de = 1'b1; hsync = 1'b1;
        tick();
        glyph = 1'b0;
        repeat (6) tick();
        reset = 1'b1; glyph = 1'b1; h_glyph = 7'd9; v_glyph = 5'd9;
        tick();
        checks++;
        if ({de_out, hsync_out, vsync_out, pixel, screen_addr, font_addr} !== 27'd0) begin
            errors++;
            $display("FAIL midline_reset got de=%b hs=%b vs=%b px=%b sa=%0d fa=%0d exp all 0",
                     de_out, hsync_out, vsync_out, pixel, screen_addr, font_addr);
        end
        reset = 1'b0; glyph = 1'b1; de = 1'b1; hsync = 1'b1;
        h_glyph = 7'd0; v_glyph = 5'd0; v_pixel = 5'd0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 1) glyph = 1'b0;
            if (k == 10) de = 1'b0;
            if (k < 5) begin
                checks++;
                if ({de_out, hsync_out, vsync_out, pixel} !== 4'b0000) begin
                    errors++;
                    $display("FAIL post_reset_quiet clock %0d got %b exp 0000", k,
                             {de_out, hsync_out, vsync_out, pixel});
                end
            end else begin
                got[14-k] = pixel;
            end
            if (k == 5) begin
                checks++;
                if ({de_out, hsync_out} !== 2'b11) begin
                    errors++; $display("FAIL post_reset_track got %b exp 11", {de_out, hsync_out});
                end
            end
        end
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL post_reset_glyph got %b exp %b", got, exp);
        end
        idle_inputs();
        repeat (6) tick();
    endtask

    task automatic vsync_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            vsync = 1'b1; tick();
            vsync = 1'b0; tick();
        end
        repeat (6) tick();
    endtask

    task automatic test_cursor;
        logic [9:0] got;
        logic [9:0] on_exp;
        on_exp = '0;
`ifdef VGA_CURSOR_EN
        on_exp = 10'h3FF;
`endif
        screen_mem[5*80+3] = 8'h00;
        screen_mem[5*80+4] = 8'h00;
        cursor_row = 5'd5; cursor_col = 7'd3; cursor_enable = 1'b1;
        reset = 1'b1; tick(); reset = 1'b0;
        repeat (6) tick();
        run_glyph(5'd5, 7'd3, 5'd7, got);
        checks++;
        if (got !== on_exp) begin
            errors++; $display("FAIL cursor_frame0 got %b exp %b", got, on_exp);
        end
        run_glyph(5'd5, 7'd4, 5'd7, got);
        checks++;
        if (got !== 10'd0) begin
            errors++; $display("FAIL cursor_other_cell got %b exp 0000000000", got);
        end
        vsync_pulses(16);
        run_glyph(5'd5, 7'd3, 5'd7, got);
        checks++;
        if (got !== 10'd0) begin
            errors++; $display("FAIL cursor_frame16 got %b exp 0000000000", got);
        end
        vsync_pulses(16);
        run_glyph(5'd5, 7'd3, 5'd7, got);
        checks++;
        if (got !== on_exp) begin
            errors++; $display("FAIL cursor_wrap got %b exp %b", got, on_exp);
        end
        cursor_enable = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) screen_mem[i] = 8'h00;
        for (int i = 0; i < 4096; i++) font_mem[i] = 10'd0;
        cursor_row = '0; cursor_col = '0; cursor_enable = 1'b0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_pipeline();
        test_back_to_back();
        test_address();
        test_inverse();
        test_sync();
        test_reset_midline();
        test_cursor();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
